rrf_alloc_ctrl: RTL and testbench

Allocation and release controller for the rename register file (RRF). Hands out up to two RRF tags per cycle to dispatch from a circular allocation pointer, and retires up to two per cycle from a circular commit pointer. Rolls the allocation pointer back on branch misprediction. Drives the RRF's dispatch-clear ports (`dpaddr*`/`dpen*`) and commit-read tags (`com*tag`), and tells dispatch when to stall.

---
 rtl/rrf_alloc_ctrl_pkg.sv | 14 +
 rtl/rrf_alloc_ctrl.sv | 120 ++++++++++++
 tb/tb_rrf_alloc_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rrf_alloc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rrf_alloc_ctrl_pkg
// Shared constants for the rename register file (RRF) allocation logic.
//   RRF_NUM_DEF : default number of RRF entries (power of two, >= 4)
//   RRF_SEL_DEF : default tag width, log2(RRF_NUM_DEF)
//   DATA_LEN    : RRF data word width, used by the RRF data array
// -----------------------------------------------------------------------------
package rrf_alloc_ctrl_pkg;

  localparam int RRF_NUM_DEF = 64;
  localparam int RRF_SEL_DEF = 6;
  localparam int DATA_LEN    = 32;

endpackage : rrf_alloc_ctrl_pkg

// File: rtl/rrf_alloc_ctrl.sv
// -----------------------------------------------------------------------------
// rrf_alloc_ctrl
// Allocation / release controller for the rename register file. Hands out up
// to two tags per cycle from a circular allocation pointer, retires up to two
// per cycle from a circular commit pointer, and rolls the allocation pointer
// back on a branch mispredict.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   reset          synchronous reset, active low
//   dp_req1/2      dispatch slots 1/2 request a tag (req2 implies req1)
//   stall_dp       demand exceeds registered free count; nothing granted
//   dpaddr1/2      tags offered to slots 1/2 (rrfptr, rrfptr+1)
//   dpen1/2        grant strobes, clear the RRF valid bits of dpaddr1/2
//   com_en1/2      ROB retires com1tag / com2tag (en2 implies en1)
//   com1tag/2tag   oldest and second-oldest live tags
//   prmiss         branch mispredict, squash everything younger than branch
//   prmiss_rrfptr  allocation pointer checkpointed just after the branch tag
//   rrfptr         current allocation pointer (checkpoint source)
//   freenum        number of free entries, 0..RRF_NUM
//
// Handshake: a tag is consumed exactly on a rising edge where its dpenN is 1;
// dpenN is combinational from registered state and the current requests, so
// dispatch and the RRF both sample the grant on that same edge. A commit is
// consumed on every edge where its com_enN is 1; no backpressure exists on
// the commit side.
// -----------------------------------------------------------------------------
module rrf_alloc_ctrl
  import rrf_alloc_ctrl_pkg::*;
#(
  parameter int RRF_NUM = RRF_NUM_DEF,
  parameter int RRF_SEL = RRF_SEL_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dp_req1,
  input  logic               dp_req2,
  output logic               stall_dp,
  output logic [RRF_SEL-1:0] dpaddr1,
  output logic [RRF_SEL-1:0] dpaddr2,
  output logic               dpen1,
  output logic               dpen2,
  input  logic               com_en1,
  input  logic               com_en2,
  output logic [RRF_SEL-1:0] com1tag,
  output logic [RRF_SEL-1:0] com2tag,
  input  logic               prmiss,
  input  logic [RRF_SEL-1:0] prmiss_rrfptr,
  output logic [RRF_SEL-1:0] rrfptr,
  output logic [RRF_SEL:0]   freenum
);

  localparam logic [RRF_SEL:0] L_FULL = (RRF_SEL+1)'(RRF_NUM);

  // Modulo-RRF_NUM add; truncation to RRF_SEL bits performs the wrap.
  function automatic logic [RRF_SEL-1:0] ptr_add(input logic [RRF_SEL-1:0] ptr,
                                                 input logic [1:0]         n);
    ptr_add = ptr + {{(RRF_SEL-2){1'b0}}, n};
  endfunction

  logic [RRF_SEL-1:0] r_rrfptr;
  logic [RRF_SEL-1:0] r_comptr;
  logic [RRF_SEL:0]   r_freenum;

  logic [1:0]         w_need;
  logic [1:0]         w_alloc;
  logic [1:0]         w_rel;
  logic               w_stall;
  logic               w_dpen1;
  logic               w_dpen2;
  logic [RRF_SEL-1:0] w_comptr_nx;
  logic [RRF_SEL-1:0] w_span;
  logic [RRF_SEL:0]   w_free_miss;
  logic [RRF_SEL:0]   w_free_norm;

  assign w_need  = {1'b0, dp_req1} + {1'b0, dp_req2};
  // Only the registered free count is used: same-cycle commits do not help,
  // which keeps com_en* out of the stall path.
  assign w_stall = {{(RRF_SEL-1){1'b0}}, w_need} > r_freenum;
  assign w_dpen1 = dp_req1 & ~w_stall & ~prmiss;
  assign w_dpen2 = dp_req2 & ~w_stall & ~prmiss;
  assign w_alloc = {1'b0, w_dpen1} + {1'b0, w_dpen2};
  assign w_rel   = {1'b0, com_en1} + {1'b0, com_en2};

  assign w_comptr_nx = ptr_add(r_comptr, w_rel);
  // Live span after rollback is [comptr', prmiss_rrfptr). A zero span means
  // the branch itself has already retired, so the file is empty, not full.
  assign w_span      = prmiss_rrfptr - w_comptr_nx;
  assign w_free_miss = L_FULL - {1'b0, w_span};
  assign w_free_norm = r_freenum + {{(RRF_SEL-1){1'b0}}, w_rel}
                                 - {{(RRF_SEL-1){1'b0}}, w_alloc};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rrfptr  <= '0;
      r_comptr  <= '0;
      r_freenum <= L_FULL;
    end else begin
      r_comptr <= w_comptr_nx;
      if (prmiss) begin
        r_rrfptr  <= prmiss_rrfptr;
        r_freenum <= w_free_miss;
      end else begin
        r_rrfptr  <= ptr_add(r_rrfptr, w_alloc);
        r_freenum <= w_free_norm;
      end
    end
  end

  assign stall_dp = w_stall;
  assign dpen1    = w_dpen1;
  assign dpen2    = w_dpen2;
  assign dpaddr1  = r_rrfptr;
  assign dpaddr2  = ptr_add(r_rrfptr, 2'd1);
  assign com1tag  = r_comptr;
  assign com2tag  = ptr_add(r_comptr, 2'd1);
  assign rrfptr   = r_rrfptr;
  assign freenum  = r_freenum;

endmodule : rrf_alloc_ctrl

// File: tb/tb_rrf_alloc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rrf_alloc_ctrl
// Self-checking bench for rrf_alloc_ctrl. The reference model keeps the live
// tags as an ordered queue (oldest first) plus the next tag to hand out.
// -----------------------------------------------------------------------------
module tb_rrf_alloc_ctrl;

  localparam int N   = 64;
  localparam int SEL = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           dp_req1, dp_req2, com_en1, com_en2, prmiss;
  logic [SEL-1:0] prmiss_rrfptr;
  logic           stall_dp, dpen1, dpen2;
  logic [SEL-1:0] dpaddr1, dpaddr2, com1tag, com2tag, rrfptr;
  logic [SEL:0]   freenum;

  rrf_alloc_ctrl #(.RRF_NUM(N), .RRF_SEL(SEL)) dut (
    .clk(clk), .reset(reset),
    .dp_req1(dp_req1), .dp_req2(dp_req2), .stall_dp(stall_dp),
    .dpaddr1(dpaddr1), .dpaddr2(dpaddr2), .dpen1(dpen1), .dpen2(dpen2),
    .com_en1(com_en1), .com_en2(com_en2), .com1tag(com1tag), .com2tag(com2tag),
    .prmiss(prmiss), .prmiss_rrfptr(prmiss_rrfptr),
    .rrfptr(rrfptr), .freenum(freenum)
  );

  // Committing more than the occupancy is illegal stimulus.
  assert property (@(posedge clk) disable iff (!reset)
    ({6'd0, com_en1} + {6'd0, com_en2}) <= (7'd64 - freenum))
    else $error("commit exceeds occupancy");

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int live_q[$];   // live tags, oldest first
  int m_next;      // next tag to allocate

  function automatic int wrap(input int v);
    return ((v % N) + N) % N;
  endfunction

  function automatic int m_head();
    return (live_q.size() != 0) ? live_q[0] : m_next;
  endfunction

  task automatic model_reset();
    live_q.delete();
    m_next = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_idle();
    dp_req1 = 0; dp_req2 = 0; com_en1 = 0; com_en2 = 0;
    prmiss = 0; prmiss_rrfptr = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_idle();
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Called at a negedge: drive one cycle, check every output against the
  // model, advance the model on the rising edge, return at the next negedge.
  task automatic step(input bit r1, input bit r2, input bit c1, input bit c2,
                      input bit pm, input int pmp);
    int free, need, keep, h;
    bit stall, g1, g2;
    dp_req1 = r1; dp_req2 = r2; com_en1 = c1; com_en2 = c2;
    prmiss = pm; prmiss_rrfptr = SEL'(pmp);
    #1;
    free  = N - live_q.size();
    need  = int'(r1) + int'(r2);
    stall = need > free;
    g1    = r1 && !stall && !pm;
    g2    = r2 && !stall && !pm;
    h     = m_head();
    check_val("stall_dp", stall_dp, stall);
    check_val("dpen1",    dpen1,    g1);
    check_val("dpen2",    dpen2,    g2);
    check_val("dpaddr1",  dpaddr1,  m_next);
    check_val("dpaddr2",  dpaddr2,  wrap(m_next + 1));
    check_val("com1tag",  com1tag,  h);
    check_val("com2tag",  com2tag,  wrap(h + 1));
    check_val("rrfptr",   rrfptr,   m_next);
    check_val("freenum",  freenum,  free);
    if (live_q.size() != 0 && live_q.size() != N)
      check_val("occupancy", wrap(int'(rrfptr) - int'(com1tag)), live_q.size());
    @(posedge clk);
    repeat (int'(c1) + int'(c2)) void'(live_q.pop_front());
    if (pm) begin
      keep = wrap(pmp - m_head());
      while (live_q.size() > keep) void'(live_q.pop_back());
      m_next = pmp;
    end else begin
      if (g1) begin live_q.push_back(m_next); m_next = wrap(m_next + 1); end
      if (g2) begin live_q.push_back(m_next); m_next = wrap(m_next + 1); end
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c, k, hd, sz;
    bit r1, r2, pm;
    reset = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset then idle
    step(0, 0, 0, 0, 0, 0);
    check_val("rst_rrfptr", rrfptr, 0);
    check_val("rst_free",   freenum, 64);
    check_val("rst_com2",   com2tag, 1);

    // Fill and wrap
    for (int i = 0; i < 32; i++) step(1, 1, 0, 0, 0, 0);
    check_val("fill_free",   freenum, 0);
    check_val("fill_rrfptr", rrfptr, 0);
    step(1, 1, 0, 0, 0, 0);                 // full: stall, nothing consumed
    check_val("full_rrfptr", rrfptr, 0);

    // Commit while full: still stalls this cycle, grants next cycle
    step(1, 0, 1, 1, 0, 0);
    check_val("cwf_free", freenum, 2);
    step(1, 1, 0, 0, 0, 0);
    check_val("cwf_comptr", com1tag, 2);

    // Partial space
    step(0, 0, 1, 0, 0, 0);
    check_val("part_free", freenum, 1);
    step(1, 1, 0, 0, 0, 0);                 // two-tag request stalls entirely
    step(1, 0, 0, 0, 0, 0);                 // one-tag request granted
    check_val("part_free0", freenum, 0);

    // Mispredict with concurrent commit
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)  step(0, 0, 1, 1, 0, 0);
    check_val("mp_pre_rrfptr", rrfptr, 40);
    check_val("mp_pre_comptr", com1tag, 10);
    check_val("mp_pre_free",   freenum, 34);
    step(1, 0, 1, 0, 1, 20);
    check_val("mp_rrfptr", rrfptr, 20);
    check_val("mp_comptr", com1tag, 11);
    check_val("mp_free",   freenum, 55);

    // Mispredict to empty
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check_val("mpe_pre_comptr", com1tag, 5);
    step(0, 0, 1, 0, 1, 6);
    check_val("mpe_free",   freenum, 64);
    check_val("mpe_rrfptr", rrfptr, 6);
    check_val("mpe_comptr", com1tag, 6);

    // Reset wins over mispredict and requests mid-operation
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0);
    reset = 1'b0;
    dp_req1 = 1; dp_req2 = 1; prmiss = 1; prmiss_rrfptr = SEL'(33);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    step(0, 0, 0, 0, 0, 0);
    check_val("midrst_free", freenum, 64);

    // Random soak, phases alternate between fill-biased and drain-biased
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        r1 = ($urandom_range(0, 99) < (((i / 200) % 2 == 0) ? 80 : 35));
        r2 = r1 && ($urandom_range(0, 1) == 1);
        sz = live_q.size();
        c  = $urandom_range(0, (sz < 2) ? sz : 2);
        if (((i / 200) % 2 == 0) && $urandom_range(0, 1) == 0) c = 0;
        pm = ($urandom_range(0, 15) == 0);
        hd = (sz > c) ? live_q[c] : m_next;
        k  = $urandom_range(0, sz - c);
        step(r1, r2, c >= 1, c == 2, pm, wrap(hd + k));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rrf_alloc_ctrl
